dma_req_arbiter: RTL and testbench

- Shares the single DMA read/write channel pair between NUM_REQ independent requesters (e.g. CPU instruction and data ports of the mock core).
- Each request is a single-cache-line read or write.
- The block grants requests round-robin, sequences the DMA go/enable/done handshakes with size fixed at 1 line, and returns read data or write completion to the granted requester.
- Sits between requester logic (mem_ctrl instances) and the AFU's dma_if.

---
 rtl/dma_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/dma_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_dma_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA request arbiter: controller state
// encoding, the fixed one-line transfer size and the pointer width helper.
package dma_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GO        = 3'd1,
    RD_WAIT   = 3'd2,
    WR_DATA   = 3'd3,
    DONE_WAIT = 3'd4,
    RESP      = 3'd5
  } arb_state_e;

  localparam int unsigned SIZE_ONE = 1;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first request at or after ptr,
// wrapping modulo NUM_REQ, and returns the pointer just past the winner.
module rr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PW      = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      next_ptr
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(ptr) + k) % NUM_REQ);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = PW'((32'(idx) + 1) % NUM_REQ);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Shares one DMA read/write channel pair among NUM_REQ requesters, one
// single-line transfer at a time, granted round-robin.
//
// Handshakes: req_ready[i] pulses in the cycle requester i is accepted (its
// req_valid and fields must be held until then); resp_valid[i] pulses once on
// completion; dma_rd_en/dma_wr_en fire only while the FIFO side is ready.
module dma_req_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned SIZE_WIDTH = 43
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         dma_rd_addr,
  output logic [ADDR_WIDTH-1:0]         dma_wr_addr,
  output logic [SIZE_WIDTH-1:0]         dma_rd_size,
  output logic [SIZE_WIDTH-1:0]         dma_wr_size,
  output logic                          dma_rd_go,
  output logic                          dma_wr_go,
  output logic                          dma_rd_en,
  input  logic                          dma_empty,
  input  logic [DATA_WIDTH-1:0]         dma_rd_data,
  input  logic                          dma_rd_done,
  output logic                          dma_wr_en,
  input  logic                          dma_full,
  output logic [DATA_WIDTH-1:0]         dma_wr_data,
  input  logic                          dma_wr_done,
  output arb_state_e                    dbg_state
);

  localparam int unsigned PW = ptr_width(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0]     grant;
  logic [PW-1:0]          next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .en       (state_q == IDLE),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Done is only looked at in DONE_WAIT, which is never entered earlier than
  // two cycles after GO, so a done left over from the previous transfer is masked.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = GO;
          ptr_d   = next_ptr;
          gnt_d   = grant;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              we_d    = req_we[i];
              wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      GO: begin
        if (we_q) state_d = WR_DATA;
        else      state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (!dma_empty) begin
          state_d = DONE_WAIT;
          rdata_d = dma_rd_data;
        end
      end
      WR_DATA: begin
        if (!dma_full) state_d = DONE_WAIT;
      end
      DONE_WAIT: begin
        if (we_q ? dma_wr_done : dma_rd_done) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    dma_rd_go  = 1'b0;
    dma_wr_go  = 1'b0;
    dma_rd_en  = 1'b0;
    dma_wr_en  = 1'b0;
    case (state_q)
      IDLE:    req_ready  = grant;
      GO: begin
        dma_rd_go = !we_q;
        dma_wr_go = we_q;
      end
      RD_WAIT: dma_rd_en  = !dma_empty;
      WR_DATA: dma_wr_en  = !dma_full;
      RESP:    resp_valid = gnt_q;
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign dma_rd_addr = addr_q;
  assign dma_wr_addr = addr_q;
  assign dma_rd_size = SIZE_WIDTH'(SIZE_ONE);
  assign dma_wr_size = SIZE_WIDTH'(SIZE_ONE);
  assign dma_wr_data = wdata_q;
  assign resp_rdata  = rdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: a 2-requester instance against a small
// DMA responder, plus a 4-requester instance for pointer wrap.
module tb_dma_req_arbiter;
  import dma_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 2-requester DUT ----------------
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_we    = '0;
  logic [127:0]  req_addr  = '0;
  logic [1023:0] req_wdata = '0;
  logic [1:0]    req_ready, resp_valid;
  logic [511:0]  resp_rdata, dma_wr_data;
  logic          busy, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
  logic [63:0]   dma_rd_addr, dma_wr_addr;
  logic [42:0]   dma_rd_size, dma_wr_size;
  logic          dma_empty   = 1'b1;
  logic          dma_full    = 1'b1;
  logic          dma_rd_done = 1'b0;
  logic          dma_wr_done = 1'b0;
  logic [511:0]  dma_rd_data = '0;
  arb_state_e    dbg_state;

  dma_req_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
    .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go), .dma_rd_en(dma_rd_en),
    .dma_empty(dma_empty), .dma_rd_data(dma_rd_data), .dma_rd_done(dma_rd_done),
    .dma_wr_en(dma_wr_en), .dma_full(dma_full), .dma_wr_data(dma_wr_data),
    .dma_wr_done(dma_wr_done), .dbg_state(dbg_state)
  );

  // ---------------- 4-requester DUT ----------------
  logic [3:0]  r4_valid = '0;
  logic [3:0]  r4_we    = '0;
  logic [63:0] r4_addr  = '0;
  logic [31:0] r4_wdata = '0;
  logic [3:0]  r4_ready, r4_resp;
  logic [7:0]  r4_rdata, r4_wr_data;
  logic        r4_busy, r4_rd_go, r4_wr_go, r4_rd_en, r4_wr_en;
  logic [15:0] r4_rd_addr, r4_wr_addr;
  logic [3:0]  r4_rd_size, r4_wr_size;
  arb_state_e  r4_state;

  dma_req_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .SIZE_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(r4_valid), .req_we(r4_we), .req_addr(r4_addr), .req_wdata(r4_wdata),
    .req_ready(r4_ready), .resp_valid(r4_resp), .resp_rdata(r4_rdata), .busy(r4_busy),
    .dma_rd_addr(r4_rd_addr), .dma_wr_addr(r4_wr_addr),
    .dma_rd_size(r4_rd_size), .dma_wr_size(r4_wr_size),
    .dma_rd_go(r4_rd_go), .dma_wr_go(r4_wr_go), .dma_rd_en(r4_rd_en),
    .dma_empty(1'b0), .dma_rd_data(8'h5A), .dma_rd_done(1'b1),
    .dma_wr_en(r4_wr_en), .dma_full(1'b0), .dma_wr_data(r4_wr_data),
    .dma_wr_done(1'b1), .dbg_state(r4_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (negedge) ----------------
  int          cyc_n = 0, ready_cyc = 0, lat = 0;
  int          rd_go_cnt = 0, wr_go_cnt = 0, rd_en_cnt = 0, wr_en_cnt = 0, resp_cnt = 0, viol = 0;
  bit          n_rd_go, n_wr_go, n_rd_en, n_wr_en;
  logic [63:0] go_addr = '0;
  logic [42:0] go_size = '0;
  logic [511:0] wr_data_seen = '0, last_rdata = '0;
  logic [0:0]  e;

  always @(negedge clk) begin
    cyc_n++;
    n_rd_go = dma_rd_go;
    n_wr_go = dma_wr_go;
    n_rd_en = dma_rd_en;
    n_wr_en = dma_wr_en;
    if (!rst) begin
      if (dma_rd_go) begin rd_go_cnt++; go_addr = dma_rd_addr; go_size = dma_rd_size; end
      if (dma_wr_go) begin wr_go_cnt++; go_addr = dma_wr_addr; go_size = dma_wr_size; end
      if (dma_rd_en) begin rd_en_cnt++; if (dma_empty) viol++; end
      if (dma_wr_en) begin wr_en_cnt++; if (dma_full) viol++; wr_data_seen = dma_wr_data; end
      if (req_ready != 0) begin
        ready_cyc = cyc_n;
        if (busy || $countones(req_ready) > 1) viol++;
      end
      if (r4_ready != 0 && (r4_busy || $countones(r4_ready) > 1)) viol++;
      if (resp_valid != 0) begin
        resp_cnt++;
        lat = cyc_n - ready_cyc;
        last_rdata = resp_rdata;
        if (exp_q.size() == 0) check("resp_unexpected", resp_valid, 2'b00);
        else begin
          e = exp_q.pop_front();
          check("resp_idx", resp_valid, 2'b01 << e);
        end
      end
    end
  end

  // ---------------- DMA responder (posedge + 2) ----------------
  int  rd_delay = 0, full_cycles = 0, stale_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  bit  rd_arm = 0, wr_arm = 0, suppress_done = 0;
  logic [511:0] rd_data_val = '0;

  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      dma_empty = 1'b1; dma_full = 1'b1; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
      rd_arm = 0; wr_arm = 0; stale_cnt = 0;
    end else begin
      dma_rd_done = (stale_cnt > 0);
      if (stale_cnt > 0) stale_cnt--;
      dma_wr_done = 1'b0;
      if (n_rd_en) begin dma_empty = 1'b1; if (!suppress_done) dma_rd_done = 1'b1; end
      if (n_wr_en) begin dma_full = 1'b1; dma_wr_done = 1'b1; end
      if (n_rd_go) begin rd_cnt = rd_delay; rd_arm = 1; end
      if (n_wr_go) begin wr_cnt = full_cycles; wr_arm = 1; end
      if (rd_arm) begin
        if (rd_cnt == 0) begin dma_empty = 1'b0; dma_rd_data = rd_data_val; rd_arm = 0; end
        else rd_cnt--;
      end
      if (wr_arm) begin
        if (wr_cnt == 0) begin dma_full = 1'b0; wr_arm = 0; end
        else wr_cnt--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic we, input logic [63:0] a, input logic [511:0] d);
    bit got = 0;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*64 +: 64]    = a;
    req_wdata[i*512 +: 512] = d;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin got = 1; exp_q.push_back(1'(i)); end
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    check("ready_seen", got, 1);
  endtask

  task automatic wait_resp(input int budget);
    int start = resp_cnt;
    bit got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clk); #1;
      if (resp_cnt != start) got = 1;
    end
    check("resp_arrived", got, 1);
  endtask

  task automatic grant4(input logic [3:0] v, input logic [3:0] exp);
    bit got = 0, idle = 0;
    r4_valid = v;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (r4_ready != 0) begin got = 1; check("rr4_grant", r4_ready, exp); end
      @(posedge clk); #1;
    end
    r4_valid = '0;
    check("rr4_ready_seen", got, 1);
    for (int c = 0; c < 20 && !idle; c++) begin
      @(negedge clk);
      if (!r4_busy) idle = 1;
    end
    check("rr4_idle", idle, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  int base, base_resp;
  bit got;
  logic [0:0] exp_k;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_go", {dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}, 0);
    check("rst_addr", dma_rd_addr, 0);
    check("rst_wdata", dma_wr_data, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rd_size_const", dma_rd_size, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single read, requester 0, data after 3 cycles
    rd_delay = 3; rd_data_val = {64{8'hAB}};
    issue(0, 1'b0, 64'h1000, '0);
    wait_resp(40);
    check("rd_latency", lat, 7);
    check("rd_go_cnt", rd_go_cnt, 1);
    check("rd_addr", go_addr, 64'h1000);
    check("rd_size", go_size, 1);
    check("rd_en_cnt", rd_en_cnt, 1);
    check("rd_rdata", last_rdata, {64{8'hAB}});
    check("rd_no_wr_go", wr_go_cnt, 0);

    // single write, requester 1, full held for 5 cycles
    full_cycles = 5;
    issue(1, 1'b1, 64'h2040, {64{8'h55}});
    wait_resp(40);
    check("wr_latency", lat, 9);
    check("wr_go_cnt", wr_go_cnt, 1);
    check("wr_addr", go_addr, 64'h2040);
    check("wr_size", go_size, 1);
    check("wr_en_cnt", wr_en_cnt, 1);
    check("wr_data", wr_data_seen, {64{8'h55}});
    check("rdata_held", resp_rdata, {64{8'hAB}});
    check("wr_no_rd_en", rd_en_cnt, 1);

    // stale rd_done held through the IDLE, GO and following cycle
    rd_delay = 3; rd_data_val = {64{8'hC3}}; stale_cnt = 3;
    base = rd_en_cnt; base_resp = resp_cnt;
    issue(0, 1'b0, 64'h3000, '0);
    wait_resp(40);
    check("stale_latency", lat, 7);
    check("stale_rd_en", rd_en_cnt - base, 1);
    check("stale_resp_once", resp_cnt - base_resp, 1);
    check("stale_rdata", last_rdata, {64{8'hC3}});

    // both requesters continuously valid: pointer is 1, so 1,0,1,0,1,0
    rd_delay = 0; base = rd_en_cnt;
    req_we = 2'b00; req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (req_ready != 0) begin
          got = 1;
          exp_k = (k % 2 == 0) ? 1'b1 : 1'b0;
          check("rr_grant", req_ready, 2'b01 << exp_k);
          exp_q.push_back(exp_k);
        end
        @(posedge clk); #1;
      end
      check("rr_ready_seen", got, 1);
    end
    req_valid = 2'b00;
    wait_resp(40);
    check("rr_rd_en_cnt", rd_en_cnt - base, 6);
    check("rr_latency_min", lat, 4);

    // reset while waiting for done; requester 0 grant leaves pointer at 1
    suppress_done = 1;
    issue(0, 1'b0, 64'h4000, '0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (dbg_state == DONE_WAIT) got = 1;
    end
    check("reached_done_wait", got, 1);
    base_resp = resp_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; suppress_done = 0;
    exp_q.delete();
    @(negedge clk);
    check("abort_state", dbg_state, IDLE);
    check("abort_busy", busy, 0);
    check("abort_outs", {resp_valid, req_ready, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}, 0);
    check("abort_addr", dma_rd_addr, 0);
    check("abort_rdata", resp_rdata, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_resp", resp_cnt - base_resp, 0);
    req_valid = 2'b11;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        got = 1;
        check("post_rst_grant", req_ready, 2'b01);
        exp_q.push_back(1'b0);
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    check("post_rst_ready_seen", got, 1);
    wait_resp(40);

    // 4 requesters: pointer 1 with only requester 3 -> grant 3, pointer wraps to 0
    grant4(4'b0001, 4'b0001);
    grant4(4'b1000, 4'b1000);
    grant4(4'b1001, 4'b0001);
    grant4(4'b0110, 4'b0010);

    check("protocol_viol", viol, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("resp_total", resp_cnt, 10);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
